spi_slave_param: RTL and testbench

- Parametrised SPI slave front end; the SPI bit clock is the system clock `clk`.
- Deserialises MSB-first MOSI frames (2 command bits + PAYLOAD_W payload bits) into `rx_data` with a one-cycle `rx_valid` strobe.
- Serialises `tx_data` onto MISO for read-data transactions.
- Adds over the previous generation: frame-abort detection, TX wait timeout, and clean frame buffering.
- Sits between the SPI pins and the RAM/register-file controller.

---
 rtl/spi_slave_param_if.sv | 25 ++
 rtl/spi_slave_param.sv | 193 +++++++++++++++++++
 tb/tb_spi_slave_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// SPI pin-side and reply-side signal bundle for spi_slave_param.
// Modports: slave = the SPI front end, master = whoever drives the pins and tx reply.
interface spi_slave_param_if #(
  parameter int PAYLOAD_W = 8,
  parameter int DATA_W    = 8
);
  logic                 MOSI;
  logic                 SS_n;
  logic                 tx_valid;
  logic [DATA_W-1:0]    tx_data;
  logic                 MISO;
  logic                 rx_valid;
  logic [PAYLOAD_W+1:0] rx_data;
  logic                 frame_err;

  modport slave (
    input  MOSI, SS_n, tx_valid, tx_data,
    output MISO, rx_valid, rx_data, frame_err
  );

  modport master (
    output MOSI, SS_n, tx_valid, tx_data,
    input  MISO, rx_valid, rx_data, frame_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave: MSB-first {cmd,payload} deserialiser with read-reply serialiser; optional odd parity via SPI_SLAVE_PARITY_EN.
// rx_valid one cycle after the last frame bit; no backpressure, tx reply waits up to TX_TIMEOUT cycles.
module spi_slave_param #(
  parameter int PAYLOAD_W  = 8,
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_param_if.slave bus
);
  localparam int W = PAYLOAD_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int IDX_W  = $clog2(W);
  localparam int WAIT_W = $clog2(TX_TIMEOUT + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic              rd_addr_done_q, rd_addr_done_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic [W-1:0]      rx_data_q, rx_data_d;
  logic              frame_err_q, frame_err_d;

  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      frame_word;
  logic              frame_last;
  logic              frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      wait_q         <= '0;
      bit_q          <= '0;
      tx_sr_q        <= '0;
      rd_addr_done_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      bit_q          <= bit_d;
      tx_sr_q        <= tx_sr_d;
      rd_addr_done_q <= rd_addr_done_d;
      miso_q         <= miso_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Current frame with this cycle's MOSI merged in at its MSB-first position.
  always_comb begin
    idx        = IDX_W'(W - 1 - int'(cnt_q));
    frame_word = shift_q;
    if (cnt_q < CNT_W'(W)) frame_word[idx] = bus.MOSI;
    frame_last = (cnt_q == CNT_W'(FRAME_LEN - 1));
`ifdef SPI_SLAVE_PARITY_EN
    frame_ok   = ^{shift_q, bus.MOSI};
`else
    frame_ok   = 1'b1;
`endif
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    bit_d          = bit_q;
    tx_sr_d        = tx_sr_q;
    rd_addr_done_d = rd_addr_done_q;
    miso_d         = 1'b0;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data_q;
    frame_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.SS_n) begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          shift_d        = '0;
          shift_d[W-1]   = bus.MOSI;
          cnt_d          = CNT_W'(1);
          if (!bus.MOSI)           state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          shift_d = frame_word;
          cnt_d   = cnt_q + CNT_W'(1);
          if (frame_last) begin
            if (!frame_ok) begin
              frame_err_d = 1'b1;
              state_d     = DONE;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = frame_word;
              if (state_q == READ_DATA) begin
                state_d = WAIT_TX;
                wait_d  = '0;
              end else begin
                state_d = DONE;
                if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
              end
            end
          end
        end
      end

      WAIT_TX: begin
        if (bus.SS_n) begin
          state_d        = IDLE;
          frame_err_d    = 1'b1;
          rd_addr_done_d = 1'b0;
        end else if (bus.tx_valid) begin
          // MSB goes out straight away; the shifter holds the remaining bits.
          miso_d  = bus.tx_data[DATA_W-1];
          tx_sr_d = bus.tx_data << 1;
          bit_d   = BIT_W'(1);
          state_d = SEND;
        end else if (wait_q == WAIT_W'(TX_TIMEOUT - 1)) begin
          frame_err_d    = 1'b1;
          rd_addr_done_d = 1'b0;
          state_d        = DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      SEND: begin
        if (bus.SS_n) begin
          state_d        = IDLE;
          frame_err_d    = 1'b1;
          rd_addr_done_d = 1'b0;
        end else if (bit_q == BIT_W'(DATA_W)) begin
          rd_addr_done_d = 1'b0;
          state_d        = DONE;
        end else begin
          miso_d  = tx_sr_q[DATA_W-1];
          tx_sr_d = tx_sr_q << 1;
          bit_d   = bit_q + BIT_W'(1);
        end
      end

      DONE: begin
        if (bus.SS_n) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param with an rx_valid/frame_err event scoreboard.
module tb_spi_slave_param;
  localparam int PAYLOAD_W = 8;
  localparam int DATA_W    = 8;
  localparam int W         = PAYLOAD_W + 2;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [W-1:0] last_rx = '0;

  typedef struct packed {
    logic         is_err;
    logic [W-1:0] data;
  } ev_t;
  ev_t exp_q[$];

  spi_slave_param_if #(.PAYLOAD_W(PAYLOAD_W), .DATA_W(DATA_W)) bus ();

  spi_slave_param #(.PAYLOAD_W(PAYLOAD_W), .DATA_W(DATA_W), .TX_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rx(input logic [W-1:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
    last_rx = d;
  endtask

  task automatic exp_err();
    exp_q.push_back('{is_err: 1'b1, data: '0});
  endtask

  task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl, input bit bad_par);
    logic [W-1:0] f;
    logic         par;
    f   = {cmd, pl};
    par = (~^f) ^ bad_par;
    bus.SS_n = 1'b0;
    tick();
    for (int i = W - 1; i >= 0; i--) begin
      bus.MOSI = f[i];
      tick();
    end
`ifdef SPI_SLAVE_PARITY_EN
    bus.MOSI = par;
    tick();
`endif
    bus.MOSI = 1'b0;
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    tick();
  endtask

  // With the slave parked in DONE, an offered reply must never reach MISO.
  task automatic check_no_tx(input string tag);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(tag, bus.MISO, 0);
    end
    bus.tx_valid = 1'b0;
  endtask

  // Scoreboard: every rx_valid / frame_err pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.rx_valid || bus.frame_err)) begin
      ev_t ev;
      n_assert++;
      assert (!(bus.rx_valid && bus.frame_err)) else begin
        n_fail++;
        $error("FAIL both_strobes: observed rx_valid=%0b frame_err=%0b expected one", bus.rx_valid, bus.frame_err);
      end
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: observed rx_valid=%0b frame_err=%0b expected none", bus.rx_valid, bus.frame_err);
      end
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        n_assert++;
        assert (bus.frame_err === ev.is_err) else begin
          n_fail++;
          $error("FAIL event_kind: observed frame_err=%0b expected %0b", bus.frame_err, ev.is_err);
        end
        if (!ev.is_err) begin
          n_assert++;
          assert (bus.rx_data === ev.data) else begin
            n_fail++;
            $error("FAIL rx_data: observed %0h expected %0h", bus.rx_data, ev.data);
          end
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.MOSI     = 1'b0;
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (2) tick();
    chk("rst_miso", bus.MISO, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    tick();

    // Write frame, one-cycle rx_valid, then DONE until SS_n rises.
    exp_rx(10'h0A5);
    send_frame(2'b00, 8'hA5, 1'b0);
    chk("wr_valid", bus.rx_valid, 1);
    chk("wr_data", bus.rx_data, 10'h0A5);
    chk("wr_err", bus.frame_err, 0);
    tick();
    chk("wr_valid_pulse", bus.rx_valid, 0);
    repeat (3) tick();
    chk("done_miso", bus.MISO, 0);
    end_frame();

    exp_rx(10'h1FF);
    send_frame(2'b01, 8'hFF, 1'b0);
    end_frame();

    // Read address then read data with a C3 reply three cycles later.
    exp_rx(10'h20F);
    send_frame(2'b10, 8'h0F, 1'b0);
    end_frame();
    exp_rx(10'h300);
    send_frame(2'b11, 8'h00, 1'b0);
    tick();
    chk("wait_miso0", bus.MISO, 0);
    tick();
    chk("wait_miso1", bus.MISO, 0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hC3;
    tick();
    bus.tx_valid = 1'b0;
    chk("send_b7", bus.MISO, 1);
    for (int b = 6; b >= 0; b--) begin
      logic [7:0] ref_word;
      ref_word = 8'hC3;
      tick();
      chk("send_bit", bus.MISO, ref_word[b]);
    end
    tick();
    chk("send_end_miso", bus.MISO, 0);
    end_frame();
    exp_rx(10'h23C);
    send_frame(2'b10, 8'h3C, 1'b0);
    check_no_tx("after_send_is_addr");
    end_frame();

    // Abort a write frame after five bits.
    bus.SS_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.MOSI = i[0];
      tick();
    end
    bus.MOSI = 1'b0;
    bus.SS_n = 1'b1;
    exp_err();
    tick();
    chk("abort_err", bus.frame_err, 1);
    chk("abort_valid", bus.rx_valid, 0);
    chk("abort_data", bus.rx_data, last_rx);
    tick();
    chk("abort_err_pulse", bus.frame_err, 0);

    // TX timeout: abort left the read address intact, so this is a data read.
    exp_rx(10'h355);
    send_frame(2'b11, 8'h55, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_early_err", bus.frame_err, 0);
      chk("to_miso", bus.MISO, 0);
    end
    exp_err();
    tick();
    chk("to_err", bus.frame_err, 1);
    end_frame();
    exp_rx(10'h366);
    send_frame(2'b11, 8'h66, 1'b0);
    check_no_tx("after_timeout_is_addr");
    end_frame();

    // Reset in the middle of a SEND.
    exp_rx(10'h399);
    send_frame(2'b11, 8'h99, 1'b0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    tick();
    bus.tx_valid = 1'b0;
    chk("rs_b7", bus.MISO, 1);
    tick();
    chk("rs_b6", bus.MISO, 0);
    tick();
    chk("rs_b5", bus.MISO, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_miso", bus.MISO, 0);
    chk("rs_valid", bus.rx_valid, 0);
    chk("rs_data", bus.rx_data, 0);
    chk("rs_err", bus.frame_err, 0);
    last_rx  = '0;
    bus.SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    exp_rx(10'h377);
    send_frame(2'b11, 8'h77, 1'b0);
    check_no_tx("after_reset_is_addr");
    end_frame();

`ifdef SPI_SLAVE_PARITY_EN
    exp_rx(10'h0A5);
    send_frame(2'b00, 8'hA5, 1'b0);
    chk("par_ok_valid", bus.rx_valid, 1);
    end_frame();
    exp_err();
    send_frame(2'b00, 8'h5A, 1'b1);
    chk("par_bad_err", bus.frame_err, 1);
    chk("par_bad_data", bus.rx_data, last_rx);
    end_frame();
`endif

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
